// File: rtl/busca_instrucao_pkg.sv
// busca_instrucao_pkg: opcodes, instruction field positions and fetch FSM states.
package busca_instrucao_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_LW = 3'd3;
  localparam logic [2:0] OP_SW = 3'd4;
  localparam logic [2:0] OP_JUMP = 3'd5;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int IMED_MSB = 7;
  localparam int IMED_LSB = 0;
  localparam int HALT_BIT = 0;
  typedef enum logic [1:0] {BUSCA, ESPERA, EXECUTA, PARADO} estado_t;
endpackage

// File: rtl/busca_instrucao_calc_proximo_pc.sv
// calc_proximo_pc: next-PC priority mux (halt > jump > taken beq > pc+1).
module calc_proximo_pc #(
  parameter int LARGURA_PC = 8
) (
  input  logic [LARGURA_PC-1:0] pc,
  input  logic [LARGURA_PC-1:0] alvo,
  input  logic [7:0]            imed,
  input  logic                  halt,
  input  logic                  jump,
  input  logic                  beq,
  input  logic                  zero,
  output logic [LARGURA_PC-1:0] pc_mais_um,
  output logic [LARGURA_PC-1:0] proximo_pc
);
  logic [LARGURA_PC-1:0] desloc;
  always_comb begin
    pc_mais_um = pc + 1'b1;
    desloc = LARGURA_PC'($signed(imed));
    proximo_pc = halt ? pc : jump ? alvo : (beq & zero) ? pc_mais_um + desloc : pc_mais_um;
  end
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage; PC, 3-cycle fetch FSM, IR and executed-instruction counter.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int LARGURA_PC = 8,
  parameter int LARGURA_INSTR = 16,
  parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic [LARGURA_PC-1:0]    mem_endereco,
  output logic                     mem_le,
  input  logic [LARGURA_INSTR-1:0] mem_dado,
  input  logic                     halt,
  input  logic                     jump,
  input  logic                     beq,
  input  logic                     zero,
  output logic [LARGURA_INSTR-1:0] instrucao,
  output logic [2:0]               OPcode,
  output logic                     bit_menos_sig,
  output logic                     instr_valida,
  output logic [LARGURA_PC-1:0]    pc,
  output logic [LARGURA_PC-1:0]    pc_mais_um,
  output logic                     parado,
  output logic [15:0]              contador
);
  estado_t estado, estado_prox;
  logic [LARGURA_PC-1:0] proximo_pc;
  calc_proximo_pc #(.LARGURA_PC(LARGURA_PC)) u_calc (
    .pc(pc),
    .alvo(instrucao[LARGURA_PC-1:0]),
    .imed(instrucao[IMED_MSB:IMED_LSB]),
    .halt(halt),
    .jump(jump),
    .beq(beq),
    .zero(zero),
    .pc_mais_um(pc_mais_um),
    .proximo_pc(proximo_pc)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado <= BUSCA;
      pc <= PC_INICIAL;
      instrucao <= '0;
      contador <= '0;
    end else begin
      estado <= estado_prox;
      if (estado == ESPERA) instrucao <= mem_dado;
      if (estado == EXECUTA) begin
        pc <= proximo_pc;
        if (contador != 16'hFFFF) contador <= contador + 16'd1;
      end
    end
  end
  // Strobes are gated by reset_n so nothing is issued while reset is held.
  always_comb begin
    estado_prox = estado == BUSCA ? ESPERA :
                  estado == ESPERA ? EXECUTA :
                  estado == EXECUTA ? (halt ? PARADO : BUSCA) : PARADO;
    mem_le = reset_n && estado == BUSCA;
    instr_valida = reset_n && estado == EXECUTA;
    parado = reset_n && estado == PARADO;
    mem_endereco = pc;
    OPcode = instrucao[OPCODE_MSB:OPCODE_LSB];
    bit_menos_sig = instrucao[HALT_BIT];
  end
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: table-driven check of fetch/next-PC behaviour plus reset/halt corner sequences.
module tb_busca_instrucao;
  logic clock = 0, reset_n = 0;
  logic halt = 0, jump = 0, beq = 0, zero = 0;
  logic [7:0] mem_endereco, pc, pc_mais_um;
  logic mem_le, bit_menos_sig, instr_valida, parado;
  logic [15:0] mem_dado = 0, instrucao, contador;
  logic [2:0] OPcode;
  logic [15:0] mem [256];
  int checks = 0, errors = 0;

  typedef struct {
    logic [15:0] palavra;
    logic halt, jump, beq, zero;
    logic [2:0] op;
    logic [7:0] pc_prox;
  } vetor_t;
  vetor_t vetores [11];

  busca_instrucao dut (
    .clock(clock), .reset_n(reset_n), .mem_endereco(mem_endereco), .mem_le(mem_le),
    .mem_dado(mem_dado), .halt(halt), .jump(jump), .beq(beq), .zero(zero),
    .instrucao(instrucao), .OPcode(OPcode), .bit_menos_sig(bit_menos_sig),
    .instr_valida(instr_valida), .pc(pc), .pc_mais_um(pc_mais_um), .parado(parado),
    .contador(contador)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (mem_le) mem_dado <= mem[mem_endereco];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic passo;
    @(posedge clock);
    #1;
  endtask

  task automatic esperar_exec(output int n);
    n = 0;
    while (!instr_valida && n < 10) begin
      passo();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] pc_esp;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    vetores[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01};
    vetores[1]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h02};
    vetores[2]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h03};
    vetores[3]  = '{16'h6005, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h05};
    vetores[4]  = '{16'h400A, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h0A};
    vetores[5]  = '{16'h40FE, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h09};
    vetores[6]  = '{16'h40FE, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h0A};
    vetores[7]  = '{16'hA0FF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'hFF};
    vetores[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
    vetores[9]  = '{16'hA007, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 8'h07};
    vetores[10] = '{16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h07};

    passo();
    passo();
    check("reset mem_le", mem_le, 0);
    check("reset instr_valida", instr_valida, 0);
    check("reset parado", parado, 0);
    check("reset pc", pc, 0);
    check("reset contador", contador, 0);
    check("reset instrucao", instrucao, 0);
    reset_n = 1;
    #1;
    check("first mem_le", mem_le, 1);
    check("first mem_endereco", mem_endereco, 0);

    pc_esp = 8'h00;
    for (int i = 0; i < 11; i++) begin
      mem[pc_esp] = vetores[i].palavra;
      esperar_exec(n);
      check($sformatf("v%0d latency", i), n, 2);
      check($sformatf("v%0d instrucao", i), instrucao, vetores[i].palavra);
      check($sformatf("v%0d OPcode", i), OPcode, vetores[i].op);
      check($sformatf("v%0d bit_menos_sig", i), bit_menos_sig, vetores[i].palavra[0]);
      halt = vetores[i].halt;
      jump = vetores[i].jump;
      beq = vetores[i].beq;
      zero = vetores[i].zero;
      passo();
      {halt, jump, beq, zero} = 4'b0000;
      check($sformatf("v%0d pc", i), pc, vetores[i].pc_prox);
      check($sformatf("v%0d mem_endereco", i), mem_endereco, vetores[i].pc_prox);
      check($sformatf("v%0d contador", i), contador, i + 1);
      check($sformatf("v%0d parado", i), parado, vetores[i].halt);
      check($sformatf("v%0d instr_valida", i), instr_valida, 0);
      pc_esp = vetores[i].pc_prox;
    end

    for (int c = 0; c < 4; c++) begin
      jump = 1;
      passo();
      jump = 0;
      check("halt parado", parado, 1);
      check("halt mem_le", mem_le, 0);
      check("halt instr_valida", instr_valida, 0);
      check("halt pc", pc, 8'h07);
      check("halt contador", contador, 11);
    end

    reset_n = 0;
    #1;
    check("reset forces parado", parado, 0);
    check("reset forces mem_le", mem_le, 0);
    passo();
    reset_n = 1;
    #1;
    check("restart pc", pc, 0);
    check("restart contador", contador, 0);
    check("restart parado", parado, 0);
    check("restart mem_le", mem_le, 1);

    mem[0] = 16'hA003;
    mem[1] = 16'h0000;
    esperar_exec(n);
    check("restart latency", n, 2);
    passo();
    check("restart pc after", pc, 8'h01);
    check("restart instrucao", instrucao, 16'hA003);
    passo();
    reset_n = 0;
    passo();
    check("mid-fetch reset instrucao", instrucao, 0);
    check("mid-fetch reset pc", pc, 0);
    mem[0] = 16'h0000;
    reset_n = 1;
    #1;
    check("after mid-fetch reset mem_le", mem_le, 1);
    jump = 1;
    passo();
    jump = 0;
    esperar_exec(n);
    check("jump in BUSCA latency", n, 1);
    passo();
    check("jump in BUSCA ignored pc", pc, 8'h01);
    check("jump in BUSCA contador", contador, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
